// File: rtl/reset_seq_pkg.sv
// Shared sequencer state encoding and default timing constants.
// Latency: n/a. Backpressure: n/a. Feature macro: RESET_SEQ_KEY_EN (consumers only).
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam int DEF_N_OUT       = 4;
    localparam int DEF_POR_CYCLES  = 50000;
    localparam int DEF_STEP_CYCLES = 1000;
    localparam int DEF_DEB_CYCLES  = 500000;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser plus debouncer; built only with RESET_SEQ_KEY_EN.
// Latency: 2 sync edges + DEB_CYCLES stable edges to move dout. Backpressure: none.
module key_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Counter only needs to reach DEB_CYCLES-1 before dout flips.
    localparam int CW = $clog2(DEB_CYCLES);

    logic [1:0]    din_sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync <= 2'b00;
            cnt      <= '0;
            dout     <= 1'b0;
        end else begin
            din_sync <= {din_sync[0], din};
            if (din_sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                dout <= din_sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset release after POR hold; debounced key restarts it when RESET_SEQ_KEY_EN is defined.
// Latency: first release POR_CYCLES+2 edges after rst falls, then one per STEP_CYCLES. Backpressure: none.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_OUT       = DEF_N_OUT,
    parameter int POR_CYCLES  = DEF_POR_CYCLES,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key,
    output logic [N_OUT-1:0] rst_out,
    output logic             ready
);

    localparam int HW = $clog2(POR_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int IW = $clog2(N_OUT + 1);

    logic [1:0]       rel_sync;
    logic             key_deb;
    logic             held;
    seq_state_t       state, state_nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic [SW-1:0]    step_cnt, step_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [N_OUT-1:0] rst_out_nxt;
    logic             ready_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_sync <= 2'b00;
        end else begin
            rel_sync <= {rel_sync[0], 1'b1};
        end
    end

`ifdef RESET_SEQ_KEY_EN
    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .clk (clk),
        .rst (rst),
        .din (key),
        .dout(key_deb)
    );
`else
    localparam int DEB_CYCLES_UNUSED = DEB_CYCLES;
    logic key_unused;
    assign key_unused = key;
    assign key_deb    = 1'b0;
`endif

    // A held key behaves like a still-asserted reset: counting resumes the edge after release.
    assign held = ~rel_sync[1] | key_deb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            step_cnt <= '0;
            idx      <= '0;
            rst_out  <= '1;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            step_cnt <= step_nxt;
            idx      <= idx_nxt;
            rst_out  <= rst_out_nxt;
            ready    <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        step_nxt    = step_cnt;
        idx_nxt     = idx;
        rst_out_nxt = rst_out;
        ready_nxt   = ready;

        if (held) begin
            state_nxt   = HOLD;
            hold_nxt    = '0;
            step_nxt    = '0;
            idx_nxt     = '0;
            rst_out_nxt = '1;
            ready_nxt   = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HW'(POR_CYCLES - 1)) begin
                        hold_nxt       = '0;
                        rst_out_nxt[0] = 1'b0;
                        if (N_OUT == 1) begin
                            ready_nxt = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            idx_nxt   = IW'(1);
                            step_nxt  = '0;
                            state_nxt = RELEASE;
                        end
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                RELEASE: begin
                    if (step_cnt == SW'(STEP_CYCLES - 1)) begin
                        step_nxt = '0;
                        for (int i = 0; i < N_OUT; i++) begin
                            if (i == int'(idx)) begin
                                rst_out_nxt[i] = 1'b0;
                            end
                        end
                        if (idx == IW'(N_OUT - 1)) begin
                            ready_nxt = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            idx_nxt = idx + IW'(1);
                        end
                    end else begin
                        step_nxt = step_cnt + SW'(1);
                    end
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised self-checking bench for reset_sequencer against a release-time model.
// Honours RESET_SEQ_KEY_EN: without it the model ignores key entirely.
module tb_reset_sequencer;

    localparam int N_OUT = 3;
    localparam int POR   = 16;
    localparam int STEP  = 4;
    localparam int DEB   = 8;
`ifdef RESET_SEQ_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             key;
    logic [N_OUT-1:0] rst_out;
    logic             ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: edges since rst fell, edge on which POR counting starts, debounced key.
    int               e;
    int               s_edge;
    bit               deb;
    bit               ksamp[$];
    bit               dins[$];
    logic [N_OUT-1:0] exp_rst_out;
    logic             exp_ready;

    reset_sequencer #(
        .N_OUT      (N_OUT),
        .POR_CYCLES (POR),
        .STEP_CYCLES(STEP),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .rst_out(rst_out),
        .ready  (ready)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic model_reset();
        e           = 0;
        s_edge      = 3;
        deb         = 1'b0;
        ksamp.delete();
        dins.delete();
        exp_rst_out = '1;
        exp_ready   = 1'b0;
    endtask

    task automatic model_edge(input bit k);
        bit din_now;
        bit held;
        bit flip;
        e++;
        ksamp.push_back(k);
        din_now = (ksamp.size() >= 3) ? ksamp[ksamp.size() - 3] : 1'b0;
        dins.push_back(din_now);
        held = (e < 3) || (KEY_EN && deb);
        if (held) s_edge = e + 1;
        flip = 1'b0;
        if (dins.size() >= DEB) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (dins[dins.size() - 1 - j] == deb) flip = 1'b0;
            end
        end
        if (flip) deb = ~deb;
        for (int i = 0; i < N_OUT; i++) begin
            exp_rst_out[i] = (e < s_edge + POR - 1 + i * STEP);
        end
        exp_ready = (exp_rst_out == '0);
        if (ksamp.size() > 64) void'(ksamp.pop_front());
        if (dins.size() > 64) void'(dins.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(key);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: rst_out=%b ready=%b, need 111/0", rst_out, ready);
        end
        repeat (5) begin
            tick();
            n_checks++;
            if (rst_out !== 3'b111 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: rst_out=%b ready=%b, need 111/0", rst_out, ready);
            end
        end
    endtask

    task automatic test_power_up();
        rst = 1'b0;
        repeat (30) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL power_up e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
            if (e == 17 || e == 18 || e == 22 || e == 26) begin
                n_checks++;
                if ((e == 17 && rst_out !== 3'b111) || (e == 18 && rst_out !== 3'b110) ||
                    (e == 22 && rst_out !== 3'b100) || (e == 26 && (rst_out !== 3'b000 || ready !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL power_up_edge e=%0d: rst_out=%b ready=%b", e, rst_out, ready);
                end
            end
        end
    endtask

    task automatic test_key_press();
        key = 1'b1;
        repeat (20) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL key_press_hi e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
        key = 1'b0;
        repeat (60) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL key_press_lo e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
        n_checks++;
        if (rst_out !== 3'b000 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL key_press_end: rst_out=%b ready=%b, need 000/1", rst_out, ready);
        end
    endtask

    task automatic test_bounce();
        int pat[4] = '{5, 2, 5, 30};
        for (int p = 0; p < 4; p++) begin
            key = (p % 2 == 0);
            repeat (pat[p]) begin
                tick();
                n_checks++;
                if (rst_out !== 3'b000 || ready !== 1'b1 || exp_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce e=%0d: rst_out=%b ready=%b model_ready=%b, need 000/1",
                             e, rst_out, ready, exp_ready);
                end
            end
        end
    endtask

    task automatic test_abort();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (22) tick();
        n_checks++;
        if (rst_out !== 3'b100 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre: rst_out=%b ready=%b, need 100/0", rst_out, ready);
        end
        key = 1'b1;
        repeat (12) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL abort_hi e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
        key = 1'b0;
        repeat (60) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL abort_lo e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_end: ready=%b, need 1", ready);
        end
    endtask

    task automatic test_mid_rst();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (19) tick();
        n_checks++;
        if (rst_out !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_rst_pre: rst_out=%b, need 110", rst_out);
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (rst_out !== 3'b111 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_async: rst_out=%b ready=%b, need 111/0", rst_out, ready);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL mid_rst_seq e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
    endtask

    task automatic test_key_long();
        key = 1'b1;
        repeat (100) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL key_long e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
        key = 1'b0;
        repeat (60) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL key_long_rel e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
    endtask

    task automatic test_random_key();
        int len;
        for (int r = 0; r < 40; r++) begin
            key = $urandom_range(0, 1);
            len = $urandom_range(1, 14);
            repeat (len) begin
                tick();
                n_checks++;
                if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL random_key e=%0d: rst_out=%b ready=%b, need %b/%b",
                             e, rst_out, ready, exp_rst_out, exp_ready);
                end
            end
        end
        key = 1'b0;
        repeat (60) begin
            tick();
            n_checks++;
            if (rst_out !== exp_rst_out || ready !== exp_ready) begin
                n_fail++;
                $display("FAIL random_tail e=%0d: rst_out=%b ready=%b, need %b/%b",
                         e, rst_out, ready, exp_rst_out, exp_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        key = 1'b0;
        model_reset();
        test_reset();
        test_power_up();
        test_key_press();
        test_bounce();
        test_abort();
        test_mid_rst();
        test_key_long();
        test_random_key();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_OUT, default 4, number of sequenced reset outputs, legal range 1..16.
REQ-002 Parameter POR_CYCLES, default 50000, hold time in clk cycles before the first release, minimum 1.
REQ-003 Parameter STEP_CYCLES, default 1000, spacing in clk cycles between successive releases, minimum 1.
REQ-004 Parameter DEB_CYCLES, default 500000, key debounce time in clk cycles, minimum 2.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port key, input, 1 bit: asynchronous push-button; high means pressed.
REQ-008 Port rst_out, output, N_OUT bits: active-high resets; bit 0 is released first.
REQ-009 Port ready, output, 1 bit: high when every rst_out bit is released.

Function
REQ-010 The FSM SHALL have three states: HOLD, RELEASE and RUN.
REQ-011 rst asserted SHALL force all rst_out bits to 1 immediately (asynchronously).
  - ready=0, state HOLD, all counters 0.
REQ-012 Deassertion of rst SHALL pass through a 2-flop release synchroniser.
  - The edge on which rst is first sampled low counts as edge 1.
  - The HOLD counter starts on edge 3.
REQ-013 In HOLD, the counter SHALL count POR_CYCLES cycles.
  - rst_out[0] falls on edge POR_CYCLES+2.
  - The FSM then enters RELEASE.
REQ-014 In RELEASE, rst_out[i] SHALL fall STEP_CYCLES edges after rst_out[i-1], i.e. on edge POR_CYCLES+2+i*STEP_CYCLES.
  - Released bits stay low; unreleased bits stay high.
REQ-015 ready SHALL rise on the same edge that rst_out[N_OUT-1] falls; the FSM then enters RUN.
REQ-016 With N_OUT=1, the FSM SHALL go from HOLD directly to RUN; rst_out[0] and ready change on the same edge.
REQ-017 key SHALL pass through a 2-flop synchroniser.
  - A debounced level changes only after the synchronised key holds the new value for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the debounce count.
REQ-018 A debounced rising edge (press) in any state SHALL do the following on the next edge:
  - set all rst_out bits to 1;
  - drive ready to 0;
  - enter HOLD.
REQ-019 While the debounced key is high, the HOLD counter SHALL stay at 0.
  - POR_CYCLES counting starts on the edge after the debounced key falls.
REQ-020 A press during RELEASE SHALL abort the sequence; the full POR_CYCLES+stagger sequence restarts after the key is released.
REQ-021 A press and rst together SHALL resolve to rst; the debouncer state is cleared.
REQ-022 Counter widths SHALL be $clog2(max count+1); counters saturate and never wrap.

Reset
REQ-023 Reset values SHALL be:
  - rst_out all 1s;
  - ready 0;
  - state HOLD;
  - synchronisers 0;
  - debounced key 0;
  - all counters 0.
REQ-024 The block SHALL have no synchronous reset path.

Configuration
REQ-025 With RESET_SEQ_KEY_EN defined, the key synchroniser and debouncer SHALL be compiled in.
REQ-026 With RESET_SEQ_KEY_EN undefined:
  - the key port SHALL remain in the port list;
  - key SHALL be ignored;
  - no debouncer logic SHALL be generated;
  - only rst starts a sequence.

Structure
REQ-027 Package reset_seq_pkg SHALL hold the FSM state typedef (HOLD, RELEASE, RUN) and the default parameter constants.
REQ-028 The debouncer SHALL be sub-module key_debounce.
  - Ports: clk, rst, din, dout; parameter DEB_CYCLES.
  - Instantiated only under RESET_SEQ_KEY_EN.

Verification
Bench: clk 50 MHz; N_OUT=3, POR_CYCLES=16, STEP_CYCLES=4, DEB_CYCLES=8; macro defined unless stated.
REQ-029 Power-up: rst high 5 cycles, then low.
  - rst_out=111 through edge 17.
  - rst_out=110 at edge 18, 100 at edge 22, 000 at edge 26.
  - ready=1 at edge 26.
REQ-030 Key press: in RUN, key high 20 cycles, then low.
  - rst_out=111 and ready=0 one edge after the debounced rise.
  - Release sequence restarts 16+ cycles after the debounced fall, then repeats the REQ-029 timing.
REQ-031 Bounce: in RUN, key pulses high 5 cycles, low 2, high 5.
  - No change on rst_out or ready.
REQ-032 Abort: press during RELEASE while rst_out=100.
  - rst_out=111 next edge after the debounced rise.
  - Full sequence afterwards.
REQ-033 Mid-sequence rst: assert rst while rst_out=110.
  - rst_out=111 within the same cycle (before the next edge).
  - Sequence restarts after rst drops.
REQ-034 Macro undefined: key held high 100 cycles in RUN.
  - rst_out stays 000 and ready stays 1.
